reg_writeback_arbiter: RTL and testbench

- Write-side initiator for the 32 x 16-bit register file.
- Collects results from two producers, buffers them, and drives both register-file write ports as packed {addr[4:0], data[15:0]} packets.
  - Source A: ALU.
  - Source B: load unit.
- Publishes a pending-write scoreboard so issue logic can stall reads of registers with writes in flight.

---
 rtl/reg_writeback_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-back arbiter: ALU and load-unit result FIFOs feed two write ports,
// with a pending-write scoreboard. Define WB_FWD_EN to add the operand-forwarding lookup.

module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 21
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic                    full,
    output logic [DEPTH-1:0][W-1:0] ord,
    output logic [DEPTH-1:0]        ord_vld
);
    logic [PTR_W:0]          wr_ptr, rd_ptr, count;
    logic [DEPTH-1:0][W-1:0] mem;

    assign count = wr_ptr - rd_ptr;
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_data;
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Entries presented oldest-first so consumers never deal with pointer wrap.
    for (genvar k = 0; k < DEPTH; k++) begin : g_ord
        assign ord[k]     = mem[rd_ptr[PTR_W-1:0] + PTR_W'(k)];
        assign ord_vld[k] = count > (PTR_W+1)'(k);
    end
endmodule

module reg_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iAluValid,
    input  logic [20:0] iAluResult,
    output logic        oAluReady,
    input  logic        iLdValid,
    input  logic [20:0] iLdResult,
    output logic        oLdReady,
    output logic        oWritePort1,
    output logic [20:0] oRegWrite1,
    output logic        oWritePort2,
    output logic [20:0] oRegWrite2,
    output logic [31:0] oPending
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]  iFwdSel,
    output logic        oFwdHit,
    output logic [15:0] oFwdData
`endif
);
    logic                    full_a, full_b, pop_a, pop_b, conflict, wr1_nxt, wr2_nxt;
    logic [DEPTH-1:0][20:0]  ord_a, ord_b;
    logic [DEPTH-1:0]        vld_a, vld_b;
    logic [4:0]              addr_a, addr_b;

    assign oAluReady = !iReset && !full_a;
    assign oLdReady  = !iReset && !full_b;

    wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(21)) u_fifo_a (
        .iClock(iClock), .iReset(iReset),
        .push(iAluValid && oAluReady), .push_data(iAluResult), .pop(pop_a),
        .full(full_a), .ord(ord_a), .ord_vld(vld_a)
    );

    wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(21)) u_fifo_b (
        .iClock(iClock), .iReset(iReset),
        .push(iLdValid && oLdReady), .push_data(iLdResult), .pop(pop_b),
        .full(full_b), .ord(ord_b), .ord_vld(vld_b)
    );

    // Same-register collision: ALU wins, load head waits a cycle.
    assign addr_a   = ord_a[0][20:16];
    assign addr_b   = ord_b[0][20:16];
    assign conflict = vld_a[0] && vld_b[0] && (addr_a == addr_b) && (addr_a != 5'd0);
    assign pop_a    = vld_a[0];
    assign pop_b    = vld_b[0] && !conflict;
    assign wr1_nxt  = pop_a && (addr_a != 5'd0);
    assign wr2_nxt  = pop_b && (addr_b != 5'd0);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oWritePort1 <= 1'b0;
            oWritePort2 <= 1'b0;
            oRegWrite1  <= '0;
            oRegWrite2  <= '0;
        end else begin
            oWritePort1 <= wr1_nxt;
            oWritePort2 <= wr2_nxt;
            if (wr1_nxt) oRegWrite1 <= ord_a[0];
            if (wr2_nxt) oRegWrite2 <= ord_b[0];
        end
    end

    always_comb begin
        oPending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_a[k]) oPending[ord_a[k][20:16]] = 1'b1;
            if (vld_b[k]) oPending[ord_b[k][20:16]] = 1'b1;
        end
        if (oWritePort1) oPending[oRegWrite1[20:16]] = 1'b1;
        if (oWritePort2) oPending[oRegWrite2[20:16]] = 1'b1;
        oPending[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last hit is the youngest; B after A within a slot.
    always_comb begin
        oFwdHit  = 1'b0;
        oFwdData = '0;
        if (iFwdSel != 5'd0) begin
            if (oWritePort1 && oRegWrite1[20:16] == iFwdSel) begin
                oFwdHit = 1'b1; oFwdData = oRegWrite1[15:0];
            end
            if (oWritePort2 && oRegWrite2[20:16] == iFwdSel) begin
                oFwdHit = 1'b1; oFwdData = oRegWrite2[15:0];
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (vld_a[k] && ord_a[k][20:16] == iFwdSel) begin
                    oFwdHit = 1'b1; oFwdData = ord_a[k][15:0];
                end
                if (vld_b[k] && ord_b[k][20:16] == iFwdSel) begin
                    oFwdHit = 1'b1; oFwdData = ord_b[k][15:0];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Randomized bench for reg_writeback_arbiter against a queue-based reference model,
// plus directed scenarios with literal expectations.

module tb_reg_writeback_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [20:0] alu_res = '0, ld_res = '0;
    logic        alu_ready, ld_ready, wp1, wp2;
    logic [20:0] rw1, rw2;
    logic [31:0] pend;

    always #5 clk = ~clk;

    reg_writeback_arbiter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .iClock(clk), .iReset(rst),
        .iAluValid(alu_valid), .iAluResult(alu_res), .oAluReady(alu_ready),
        .iLdValid(ld_valid), .iLdResult(ld_res), .oLdReady(ld_ready),
        .oWritePort1(wp1), .oRegWrite1(rw1),
        .oWritePort2(wp2), .oRegWrite2(rw2),
        .oPending(pend)
    );

    // Reference model: FIFO contents as queues, producers as send queues.
    logic [20:0] qa[$], qb[$], send_a[$], send_b[$];
    logic        ew1 = 1'b0, ew2 = 1'b0;
    logic [20:0] er1 = '0, er2 = '0;
    bit          acc_a, acc_b;
    int          n_cmp = 0, n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pend();
        logic [31:0] p = '0;
        foreach (qa[i]) p[qa[i][20:16]] = 1'b1;
        foreach (qb[i]) p[qb[i][20:16]] = 1'b1;
        if (ew1) p[er1[20:16]] = 1'b1;
        if (ew2) p[er2[20:16]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_step();
        bit pa, pb, conf;
        logic [20:0] h;
        if (rst) begin
            qa.delete(); qb.delete();
            ew1 = 0; ew2 = 0; er1 = '0; er2 = '0; acc_a = 0; acc_b = 0;
            return;
        end
        acc_a = alu_valid && qa.size() < DEPTH;
        acc_b = ld_valid && qb.size() < DEPTH;
        pa = qa.size() != 0;
        pb = qb.size() != 0;
        conf = pa && pb && qa[0][20:16] == qb[0][20:16] && qa[0][20:16] != 5'd0;
        ew1 = 0; ew2 = 0;
        if (pa) begin
            h = qa.pop_front();
            if (h[20:16] != 5'd0) begin ew1 = 1; er1 = h; end
        end
        if (pb && !conf) begin
            h = qb.pop_front();
            if (h[20:16] != 5'd0) begin ew2 = 1; er2 = h; end
        end
        if (acc_a) begin qa.push_back(alu_res); void'(send_a.pop_front()); end
        if (acc_b) begin qb.push_back(ld_res);  void'(send_b.pop_front()); end
    endtask

    // Producers hold an unaccepted packet; otherwise present the next one unless idling.
    task automatic drive(int gap);
        if (!(alu_valid && !acc_a)) begin
            alu_valid = send_a.size() != 0 && int'($urandom_range(99)) >= gap;
            if (alu_valid) alu_res = send_a[0];
        end
        if (!(ld_valid && !acc_b)) begin
            ld_valid = send_b.size() != 0 && int'($urandom_range(99)) >= gap;
            if (ld_valid) ld_res = send_b[0];
        end
    endtask

    // Ends 1 time unit after the falling edge, once the compare process has run.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("ready_a", 32'(alu_ready), 32'(!rst && qa.size() < DEPTH));
        check("ready_b", 32'(ld_ready),  32'(!rst && qb.size() < DEPTH));
        check("wport1",  32'(wp1), 32'(ew1));
        check("wport2",  32'(wp2), 32'(ew2));
        if (ew1) check("regwrite1", 32'(rw1), 32'(er1));
        if (ew2) check("regwrite2", 32'(rw2), 32'(er2));
        check("pending", pend, exp_pend());
    end

    initial begin
        int c1, c2;
        #1 rst = 1'b1;
        #1;
        check("rst_wp1", 32'(wp1), 0);
        check("rst_wp2", 32'(wp2), 0);
        check("rst_rw1", 32'(rw1), 0);
        check("rst_pend", pend, 0);
        check("rst_ready_a", 32'(alu_ready), 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rel_ready_a", 32'(alu_ready), 1);
        check("rel_ready_b", 32'(ld_ready), 1);

        // Single write
        send_a.push_back({5'd5, 16'h1234});
        drive(0); tick();
        check("single_pend_q", pend, 32'h20);
        check("single_wp1_q", 32'(wp1), 0);
        drive(0); tick();
        check("single_wp1", 32'(wp1), 1);
        check("single_rw1", 32'(rw1), 32'h051234);
        check("single_wp2", 32'(wp2), 0);
        check("single_pend", pend, 32'h20);
        drive(0); tick();
        check("single_wp1_off", 32'(wp1), 0);
        check("single_pend_off", pend, 0);

        // Dual write
        send_a.push_back({5'd3, 16'hAAAA});
        send_b.push_back({5'd4, 16'h5555});
        drive(0); tick();
        check("dual_pend_q", pend, 32'h18);
        drive(0); tick();
        check("dual_wp1", 32'(wp1), 1);
        check("dual_wp2", 32'(wp2), 1);
        check("dual_rw2", 32'(rw2), 32'h045555);
        check("dual_pend", pend, 32'h18);
        drive(0); tick();
        check("dual_pend_off", pend, 0);

        // Conflict on r7
        send_a.push_back({5'd7, 16'h0001});
        send_b.push_back({5'd7, 16'h0002});
        drive(0); tick();
        drive(0); tick();
        check("conf_wp1", 32'(wp1), 1);
        check("conf_rw1", 32'(rw1), 32'h070001);
        check("conf_wp2_held", 32'(wp2), 0);
        check("conf_pend7a", pend, 32'h80);
        drive(0); tick();
        check("conf_wp1_off", 32'(wp1), 0);
        check("conf_wp2", 32'(wp2), 1);
        check("conf_rw2", 32'(rw2), 32'h070002);
        check("conf_pend7b", pend, 32'h80);
        drive(0); tick();
        check("conf_pend_off", pend, 0);

        // Persistent conflict backs up B until full
        for (int i = 0; i < 8; i++) send_a.push_back({5'd9, 16'(16'hA000 + i)});
        for (int i = 0; i < 5; i++) send_b.push_back({5'd9, 16'(16'hB000 + i)});
        c1 = 0; c2 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0); tick();
            c1 += int'(wp1); c2 += int'(wp2);
        end
        check("full_ready_b", 32'(ld_ready), 0);
        check("full_ld_held", 32'(ld_valid), 1);
        for (int i = 0; i < 16; i++) begin
            drive(0); tick();
            c1 += int'(wp1); c2 += int'(wp2);
        end
        check("full_cnt1", 32'(c1), 8);
        check("full_cnt2", 32'(c2), 5);

        // r0 drop
        send_a.push_back({5'd0, 16'hFFFF});
        for (int i = 0; i < 3; i++) begin
            drive(0); tick();
            check("r0_wp1", 32'(wp1), 0);
            check("r0_pend", pend, 0);
        end

        // Reset mid-operation
        for (int i = 0; i < 3; i++) send_a.push_back({5'd12, 16'(16'hC000 + i)});
        drive(0); tick();
        drive(0); tick();
        rst = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
        send_a.delete(); send_b.delete();
        #1;
        check("mid_rst_wp1", 32'(wp1), 0);
        check("mid_rst_rw1", 32'(rw1), 0);
        check("mid_rst_pend", pend, 0);
        check("mid_rst_ready", 32'(alu_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(alu_ready), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0); tick();
            check("mid_no_strobe", 32'({wp1, wp2}), 0);
        end

        // Randomized traffic with one reset in the middle
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                rst = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
                send_a.delete(); send_b.delete();
                tick();
                rst = 1'b0;
            end
            if (send_a.size() < 3 && $urandom_range(99) < 60)
                send_a.push_back({5'($urandom_range(7)), 16'($urandom)});
            if (send_b.size() < 3 && $urandom_range(99) < 60)
                send_b.push_back({5'($urandom_range(7)), 16'($urandom)});
            drive(25);
            tick();
        end
        for (int i = 0; i < 30; i++) begin
            drive(0); tick();
        end
        check("drain_pend", pend, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
